multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle RV32I core. Sequences the shared ALU, unified memory,
//  IR/PC/register-file enables and datapath muxes per instruction, using the opcode and ALU-op
//  encodings of pa_riscv. Sits between the instruction register and the multicycle datapath.
// PARAMETERS
//  none (opcode/ALU-op encodings come from pa_riscv::ty_INSTRUCTION_TYPE / ty_ALU_OP)
// PORTS
//  i_clk         in   1  clock; all state changes on rising edge
//  i_rst         in   1  synchronous, active-high reset
//  i_opcode      in   7  IR[6:0]
//  i_funct3      in   3  IR[14:12]
//  i_funct7b5    in   1  IR[30]
//  i_zero        in   1  ALU zero flag (combinational, current cycle)
//  i_memReady    in   1  memory access completes this cycle
//  o_pcWrite     out  1  PC register enable
//  o_adrSrc      out  1  memory address: 0=PC, 1=Result
//  o_memWrite    out  1  memory write strobe
//  o_irWrite     out  1  IR and OldPC enable
//  o_resultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  o_aluSrcA     out  2  00=PC, 01=OldPC, 10=RD1
//  o_aluSrcB     out  2  00=RD2, 01=ImmExt, 10=const 4
//  o_immSrc      out  2  00=I, 01=S, 10=B, 11=J
//  o_regWrite    out  1  register-file write enable
//  o_aluControl  out  4  ty_ALU_OP (ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100)
//  o_retire      out  1  one-cycle pulse in final cycle of each completed instruction
//  o_illegal     out  1  sticky: unsupported instruction decoded; cleared only by reset
// BEHAVIOUR
//  - Registered state; outputs combinational from state plus i_memReady/i_zero/i_funct3/i_funct7b5.
//  - Reset: state<=FETCH, o_illegal<=0. While i_rst=1 all enables (pcWrite, memWrite, irWrite,
//    regWrite, retire) forced 0; muxes hold FETCH values (adrSrc=0, aluSrcA=00, aluSrcB=10,
//    resultSrc=10, immSrc=00, aluControl=ADD). Reset mid-instruction aborts it, no writes.
//  - FETCH: adr=PC, ALU=PC+4, resultSrc=10. Hold until i_memReady; in that cycle irWrite=1,
//    pcWrite=1, go DECODE. No enable asserted while waiting.
//  - DECODE: aluSrcA=01, aluSrcB=01, immSrc=10, ADD (branch target -> ALUOut). Next by opcode:
//    LW/SW->MEM_ADR; R_TYPE_ALU->EXECUTE_R; I_TYPE_ALU->EXECUTE_I; B_TYPE->BRANCH; JAL->JAL;
//    any other opcode->ILLEGAL.
//  - MEM_ADR: aluSrcA=10, aluSrcB=01, ADD, immSrc=00 (LW) / 01 (SW). LW->MEM_READ, SW->MEM_WRITE.
//  - MEM_READ: adrSrc=1, resultSrc=00; hold until i_memReady, then MEM_WB.
//  - MEM_WB: resultSrc=01, regWrite=1, retire=1 -> FETCH.
//  - MEM_WRITE: adrSrc=1, resultSrc=00, memWrite=1 every cycle until i_memReady; in the
//    i_memReady cycle retire=1 -> FETCH.
//  - EXECUTE_R: aluSrcA=10, aluSrcB=00, aluControl={funct7b5,funct3}; only ADD/SUB/AND/OR/XOR
//    legal, else ->ILLEGAL (no write). Legal -> ALU_WB.
//  - EXECUTE_I: aluSrcA=10, aluSrcB=01, immSrc=00, aluControl={1'b0,funct3}; funct3 in
//    {000,111,110,100} legal (funct7b5 ignored), else ->ILLEGAL. Legal -> ALU_WB.
//  - JAL: aluSrcA=01, aluSrcB=10, ADD (OldPC+4), resultSrc=00 (target from ALUOut), pcWrite=1
//    -> ALU_WB.
//  - ALU_WB: resultSrc=00, regWrite=1, retire=1 -> FETCH.
//  - BRANCH: aluSrcA=10, aluSrcB=00, SUB, resultSrc=00. funct3=000 (BEQ): pcWrite=i_zero;
//    001 (BNE): pcWrite=~i_zero; other funct3 ->ILLEGAL, no pcWrite. Legal: retire=1 -> FETCH.
//  - ILLEGAL: o_illegal<=1; all enables 0; terminal until i_rst.
//  - Cycle counts with i_memReady=1: LW 5, SW 4, R/I-ALU 4, JAL 4, BEQ/BNE 3. Each wait
//    cycle with i_memReady=0 adds one cycle in FETCH/MEM_READ/MEM_WRITE.
//  - Never assert regWrite and memWrite together; irWrite only in FETCH.
// TESTING
//  1 Reset 3 cycles, memReady=1, opcode=0110011,f3=000,f7b5=1 -> F,D,EXR(aluCtl=1000),WB; retire
//    cycle 4 of instr.
//  2 LW (0000011), memReady low 2 cycles in MEM_READ -> 7 cycles; regWrite only in MEM_WB,
//    resultSrc=01.
//  3 SW (0100011), memReady low 1 cycle -> memWrite high 2 cycles, adrSrc=1, retire once.
//  4 B_TYPE f3=000 zero=1 -> pcWrite=1 in BRANCH; f3=001 zero=1 -> pcWrite=0; both 3 cycles.
//  5 opcode=0110111 (LUI) -> ILLEGAL after DECODE, o_illegal=1 sticky, no writes; i_rst clears.
//  6 JAL (1101111) -> pcWrite in JAL and FETCH only, regWrite in ALU_WB; i_rst pulse during
//    EXECUTE_I -> next cycle FETCH, regWrite never seen.

Source files
------------

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multicycle RV32I core. It steps each instruction
// through fetch, decode and its execute/memory/writeback phases. Along the way
// it drives the enables and mux selects that share one ALU and one unified
// memory across all phases of an instruction.
//
// Ports
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset
//   i_opcode      IR[6:0]
//   i_funct3      IR[14:12]
//   i_funct7b5    IR[30]
//   i_zero        ALU zero flag for the current cycle
//   i_memReady    memory access completes this cycle
//   o_pcWrite     PC register enable
//   o_adrSrc      memory address select (0 = PC, 1 = Result)
//   o_memWrite    memory write strobe
//   o_irWrite     IR / OldPC enable
//   o_resultSrc   00 = ALUOut, 01 = Data, 10 = ALUResult
//   o_aluSrcA     00 = PC, 01 = OldPC, 10 = RD1
//   o_aluSrcB     00 = RD2, 01 = ImmExt, 10 = constant 4
//   o_immSrc      00 = I, 01 = S, 10 = B, 11 = J
//   o_regWrite    register-file write enable
//   o_aluControl  ALU operation (ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100)
//   o_retire      one-cycle pulse in the last cycle of a completed instruction
//   o_illegal     sticky flag, set on an unsupported instruction until reset
// ---------------------------------------------------------------------------
module multicycle_controller (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_immSrc,
    output logic       o_regWrite,
    output logic [3:0] o_aluControl,
    output logic       o_retire,
    output logic       o_illegal
);

    // Opcode and ALU-op encodings, matching pa_riscv
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE_R,
        S_EXECUTE_I,
        S_JAL,
        S_ALU_WB,
        S_BRANCH,
        S_ILLEGAL
    } stateT;

    stateT state_q, state_d;
    logic  illegal_q;
    logic  rLegal;
    logic  iLegal;

    // Only ADD/SUB/AND/OR/XOR are implemented. R-type uses funct7b5 to tell
    // SUB from ADD. I-type ignores it, so SUB is never reachable from an
    // immediate.
    always_comb begin
        rLegal = 1'b0;
        iLegal = 1'b0;
        case ({i_funct7b5, i_funct3})
            4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100: rLegal = 1'b1;
            default:                                     rLegal = 1'b0;
        endcase
        case (i_funct3)
            3'b000, 3'b111, 3'b110, 3'b100: iLegal = 1'b1;
            default:                        iLegal = 1'b0;
        endcase
    end

    // Output and next-state decode. The defaults are the FETCH mux settings
    // with every enable low. Each state overrides only what it needs.
    // Reset overrides everything last, so an instruction cut off by reset
    // performs no write.
    always_comb begin
        state_d      = state_q;
        o_pcWrite    = 1'b0;
        o_adrSrc     = 1'b0;
        o_memWrite   = 1'b0;
        o_irWrite    = 1'b0;
        o_resultSrc  = 2'b10;
        o_aluSrcA    = 2'b00;
        o_aluSrcB    = 2'b10;
        o_immSrc     = 2'b00;
        o_regWrite   = 1'b0;
        o_aluControl = ALU_ADD;
        o_retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (i_memReady) begin
                    o_irWrite = 1'b1;
                    o_pcWrite = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // The ALU is idle here, so it precomputes the branch target into ALUOut
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b01;
                o_immSrc  = 2'b10;
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_EXECUTE_R;
                    OP_I:         state_d = S_EXECUTE_I;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
                o_immSrc  = (i_opcode == OP_SW) ? 2'b01 : 2'b00;
                state_d   = (i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                o_adrSrc    = 1'b1;
                o_resultSrc = 2'b00;
                if (i_memReady) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                o_resultSrc = 2'b01;
                o_regWrite  = 1'b1;
                o_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WRITE: begin
                // The strobe stays high through every wait cycle and the ready cycle
                o_adrSrc    = 1'b1;
                o_resultSrc = 2'b00;
                o_memWrite  = 1'b1;
                if (i_memReady) begin
                    o_retire = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECUTE_R: begin
                o_aluSrcA    = 2'b10;
                o_aluSrcB    = 2'b00;
                o_aluControl = {i_funct7b5, i_funct3};
                state_d      = rLegal ? S_ALU_WB : S_ILLEGAL;
            end
            S_EXECUTE_I: begin
                o_aluSrcA    = 2'b10;
                o_aluSrcB    = 2'b01;
                o_aluControl = {1'b0, i_funct3};
                state_d      = iLegal ? S_ALU_WB : S_ILLEGAL;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4 as the link
                o_aluSrcA   = 2'b01;
                o_aluSrcB   = 2'b10;
                o_resultSrc = 2'b00;
                o_pcWrite   = 1'b1;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                o_resultSrc = 2'b00;
                o_regWrite  = 1'b1;
                o_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                o_aluSrcA    = 2'b10;
                o_aluSrcB    = 2'b00;
                o_aluControl = ALU_SUB;
                o_resultSrc  = 2'b00;
                case (i_funct3)
                    3'b000: begin
                        o_pcWrite = i_zero;
                        o_retire  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    3'b001: begin
                        o_pcWrite = ~i_zero;
                        o_retire  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (i_rst) begin
            state_d      = S_FETCH;
            o_pcWrite    = 1'b0;
            o_adrSrc     = 1'b0;
            o_memWrite   = 1'b0;
            o_irWrite    = 1'b0;
            o_resultSrc  = 2'b10;
            o_aluSrcA    = 2'b00;
            o_aluSrcB    = 2'b10;
            o_immSrc     = 2'b00;
            o_regWrite   = 1'b0;
            o_aluControl = ALU_ADD;
            o_retire     = 1'b0;
        end
    end

    // State register. The illegal flag is set on the edge that enters
    // ILLEGAL, so it is already visible in the first ILLEGAL cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Bench for multicycle_controller. An instruction-level table checks cycle
// counts and enable totals. A reference model turns each whole instruction
// into its expected cycle-by-cycle trace, and that trace drives the directed
// corner cases and a randomized instruction stream.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [4:0] EN_PC  = 5'b10000;
    localparam logic [4:0] EN_MEM = 5'b01000;
    localparam logic [4:0] EN_IR  = 5'b00100;
    localparam logic [4:0] EN_REG = 5'b00010;
    localparam logic [4:0] EN_RET = 5'b00001;

    localparam int ADD = 0;
    localparam int SUB = 8;
    localparam int DC  = -1;

    // Phase labels used only in messages
    localparam logic [3:0] T_RESET = 0,  T_FETCH = 1,  T_DECODE = 2,  T_MEMADR = 3;
    localparam logic [3:0] T_MEMRD = 4,  T_MEMWB = 5,  T_MEMWR  = 6,  T_EXR    = 7;
    localparam logic [3:0] T_EXI   = 8,  T_JAL   = 9,  T_ALUWB  = 10, T_BRANCH = 11;
    localparam logic [3:0] T_ILL   = 12, T_ABORT = 13;

    logic       clock;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, retire, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [3:0] aluControl;

    multicycle_controller dut (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_opcode     (opcode),
        .i_funct3     (funct3),
        .i_funct7b5   (funct7b5),
        .i_zero       (zero),
        .i_memReady   (memReady),
        .o_pcWrite    (pcWrite),
        .o_adrSrc     (adrSrc),
        .o_memWrite   (memWrite),
        .o_irWrite    (irWrite),
        .o_resultSrc  (resultSrc),
        .o_aluSrcA    (aluSrcA),
        .o_aluSrcB    (aluSrcB),
        .o_immSrc     (immSrc),
        .o_regWrite   (regWrite),
        .o_aluControl (aluControl),
        .o_retire     (retire),
        .o_illegal    (illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One expected cycle: inputs to apply plus outputs to require. The care
    // bits mark the mux selects that matter in that phase: adr, result,
    // srcA, srcB, imm, alu.
    typedef struct packed {
        logic [3:0] tag;
        logic       rst;
        logic       memReady;
        logic       zero;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] en;
        logic       illegal;
        logic       adrSrc;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] immSrc;
        logic [3:0] aluCtl;
        logic [5:0] care;
    } cycleT;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         cycles;
        int         pcW;
        int         regW;
        int         memW;
        int         ill;
    } vecT;

    cycleT      trace[$];
    logic [6:0] curOpc;
    logic [2:0] curF3;
    logic       curF7;
    logic       modelIllegal;
    int         vectors;
    int         miscompares;

    function automatic string tagName(input logic [3:0] t);
        case (t)
            T_RESET:  return "RESET";
            T_FETCH:  return "FETCH";
            T_DECODE: return "DECODE";
            T_MEMADR: return "MEM_ADR";
            T_MEMRD:  return "MEM_READ";
            T_MEMWB:  return "MEM_WB";
            T_MEMWR:  return "MEM_WRITE";
            T_EXR:    return "EXEC_R";
            T_EXI:    return "EXEC_I";
            T_JAL:    return "JAL";
            T_ALUWB:  return "ALU_WB";
            T_BRANCH: return "BRANCH";
            T_ILL:    return "ILLEGAL";
            default:  return "ABORT";
        endcase
    endfunction

    function automatic cycleT blank(input logic [3:0] t);
        cycleT c;
        c          = '0;
        c.tag      = t;
        c.opcode   = curOpc;
        c.f3       = curF3;
        c.f7       = curF7;
        c.memReady = 1'($urandom_range(0, 1));
        c.zero     = 1'($urandom_range(0, 1));
        c.illegal  = modelIllegal;
        return c;
    endfunction

    function automatic cycleT mux(input cycleT ci, input int adr, input int res,
                                  input int sa, input int sb, input int imm, input int alu);
        cycleT c;
        c = ci;
        if (adr >= 0) begin c.adrSrc    = adr[0];   c.care[5] = 1'b1; end
        if (res >= 0) begin c.resultSrc = res[1:0]; c.care[4] = 1'b1; end
        if (sa  >= 0) begin c.aluSrcA   = sa[1:0];  c.care[3] = 1'b1; end
        if (sb  >= 0) begin c.aluSrcB   = sb[1:0];  c.care[2] = 1'b1; end
        if (imm >= 0) begin c.immSrc    = imm[1:0]; c.care[1] = 1'b1; end
        if (alu >= 0) begin c.aluCtl    = alu[3:0]; c.care[0] = 1'b1; end
        return c;
    endfunction

    // Reference model: each call appends the full cycle trace of one event

    task automatic addReset(input int n);
        cycleT c;
        for (int i = 0; i < n; i++) begin
            c     = mux(blank(T_RESET), 0, 2, 0, 2, 0, ADD);
            c.rst = 1'b1;
            trace.push_back(c);
            modelIllegal = 1'b0;
        end
    endtask

    task automatic enterIllegal();
        modelIllegal = 1'b1;
        for (int i = 0; i < 2; i++) trace.push_back(blank(T_ILL));
        addReset(1);
    endtask

    task automatic pushFetchDecode(input int fw);
        cycleT c;
        for (int i = 0; i < fw; i++) begin
            c          = mux(blank(T_FETCH), 0, 2, 0, 2, 0, ADD);
            c.memReady = 1'b0;
            trace.push_back(c);
        end
        c          = mux(blank(T_FETCH), 0, 2, 0, 2, 0, ADD);
        c.memReady = 1'b1;
        c.en       = EN_PC | EN_IR;
        trace.push_back(c);
        trace.push_back(mux(blank(T_DECODE), DC, DC, 1, 1, 2, ADD));
    endtask

    task automatic buildInstr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic z, input int fw, input int mw);
        cycleT c;
        logic  legal;
        curOpc = opc;
        curF3  = f3;
        curF7  = f7;
        pushFetchDecode(fw);
        case (opc)
            OP_LW, OP_SW: begin
                trace.push_back(mux(blank(T_MEMADR), DC, DC, 2, 1, (opc == OP_SW) ? 1 : 0, ADD));
                for (int i = 0; i <= mw; i++) begin
                    c          = mux(blank((opc == OP_SW) ? T_MEMWR : T_MEMRD), 1, 0, DC, DC, DC, DC);
                    c.memReady = (i == mw);
                    if (opc == OP_SW) c.en = EN_MEM | ((i == mw) ? EN_RET : 5'b0);
                    trace.push_back(c);
                end
                if (opc == OP_LW) begin
                    c    = mux(blank(T_MEMWB), DC, 1, DC, DC, DC, DC);
                    c.en = EN_REG | EN_RET;
                    trace.push_back(c);
                end
            end
            OP_R, OP_I: begin
                if (opc == OP_R) begin
                    legal = ({f7, f3} inside {4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100});
                    trace.push_back(mux(blank(T_EXR), DC, DC, 2, 0, DC, int'({f7, f3})));
                end else begin
                    legal = (f3 inside {3'b000, 3'b111, 3'b110, 3'b100});
                    trace.push_back(mux(blank(T_EXI), DC, DC, 2, 1, 0, int'({1'b0, f3})));
                end
                if (legal) begin
                    c    = mux(blank(T_ALUWB), DC, 0, DC, DC, DC, DC);
                    c.en = EN_REG | EN_RET;
                    trace.push_back(c);
                end else begin
                    enterIllegal();
                end
            end
            OP_JAL: begin
                c    = mux(blank(T_JAL), DC, 0, 1, 2, DC, ADD);
                c.en = EN_PC;
                trace.push_back(c);
                c    = mux(blank(T_ALUWB), DC, 0, DC, DC, DC, DC);
                c.en = EN_REG | EN_RET;
                trace.push_back(c);
            end
            OP_B: begin
                c      = mux(blank(T_BRANCH), DC, 0, 2, 0, DC, SUB);
                c.zero = z;
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    c.en = EN_RET | (((f3 == 3'b000) == z) ? EN_PC : 5'b0);
                    trace.push_back(c);
                end else begin
                    trace.push_back(c);
                    enterIllegal();
                end
            end
            default: enterIllegal();
        endcase
    endtask

    task automatic applyStimulus(input cycleT e);
        reset    = e.rst;
        opcode   = e.opcode;
        funct3   = e.f3;
        funct7b5 = e.f7;
        zero     = e.zero;
        memReady = e.memReady;
    endtask

    task automatic checkOutput(input cycleT e);
        logic bad;
        bad = ({pcWrite, memWrite, irWrite, regWrite, retire} !== e.en) || (illegal !== e.illegal);
        if (e.care[5] && adrSrc     !== e.adrSrc)    bad = 1'b1;
        if (e.care[4] && resultSrc  !== e.resultSrc) bad = 1'b1;
        if (e.care[3] && aluSrcA    !== e.aluSrcA)   bad = 1'b1;
        if (e.care[2] && aluSrcB    !== e.aluSrcB)   bad = 1'b1;
        if (e.care[1] && immSrc     !== e.immSrc)    bad = 1'b1;
        if (e.care[0] && aluControl !== e.aluCtl)    bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s opc=%b f3=%b: got en=%b ill=%b adr=%b res=%b a=%b b=%b imm=%b alu=%b, want en=%b ill=%b adr=%b res=%b a=%b b=%b imm=%b alu=%b care=%b",
                     tagName(e.tag), e.opcode, e.f3,
                     {pcWrite, memWrite, irWrite, regWrite, retire}, illegal, adrSrc, resultSrc,
                     aluSrcA, aluSrcB, immSrc, aluControl,
                     e.en, e.illegal, e.adrSrc, e.resultSrc, e.aluSrcA, e.aluSrcB, e.immSrc,
                     e.aluCtl, e.care);
        end
    endtask

    task automatic runTrace();
        cycleT e;
        while (trace.size() > 0) begin
            e = trace.pop_front();
            applyStimulus(e);
            @(negedge clock);
            checkOutput(e);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic rawReset();
        reset    = 1'b1;
        memReady = 1'b0;
        @(posedge clock);
        #1;
        reset        = 1'b0;
        modelIllegal = 1'b0;
    endtask

    vecT vecs[19];

    initial begin
        cycleT c;
        int    cyc, pcW, regW, memW, ill;
        logic  done;

        vecs[0]  = '{OP_R,   3'b000, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[1]  = '{OP_R,   3'b000, 1'b1, 1'b1, 4, 1, 1, 0, 0};
        vecs[2]  = '{OP_R,   3'b111, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[3]  = '{OP_R,   3'b110, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[4]  = '{OP_R,   3'b100, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[5]  = '{OP_R,   3'b001, 1'b0, 1'b0, 4, 1, 0, 0, 1};
        vecs[6]  = '{OP_R,   3'b111, 1'b1, 1'b0, 4, 1, 0, 0, 1};
        vecs[7]  = '{OP_I,   3'b000, 1'b1, 1'b0, 4, 1, 1, 0, 0};
        vecs[8]  = '{OP_I,   3'b110, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[9]  = '{OP_I,   3'b010, 1'b0, 1'b0, 4, 1, 0, 0, 1};
        vecs[10] = '{OP_LW,  3'b010, 1'b0, 1'b0, 5, 1, 1, 0, 0};
        vecs[11] = '{OP_SW,  3'b010, 1'b0, 1'b0, 4, 1, 0, 1, 0};
        vecs[12] = '{OP_B,   3'b000, 1'b0, 1'b1, 3, 2, 0, 0, 0};
        vecs[13] = '{OP_B,   3'b000, 1'b0, 1'b0, 3, 1, 0, 0, 0};
        vecs[14] = '{OP_B,   3'b001, 1'b0, 1'b1, 3, 1, 0, 0, 0};
        vecs[15] = '{OP_B,   3'b001, 1'b0, 1'b0, 3, 2, 0, 0, 0};
        vecs[16] = '{OP_B,   3'b100, 1'b0, 1'b0, 4, 1, 0, 0, 1};
        vecs[17] = '{OP_JAL, 3'b000, 1'b0, 1'b0, 4, 2, 1, 0, 0};
        vecs[18] = '{OP_LUI, 3'b000, 1'b0, 1'b0, 3, 1, 0, 0, 1};

        vectors      = 0;
        miscompares  = 0;
        modelIllegal = 1'b0;
        curOpc       = OP_R;
        curF3        = 3'b000;
        curF7        = 1'b1;
        opcode       = OP_R;
        funct3       = 3'b000;
        funct7b5     = 1'b1;
        zero         = 1'b0;
        rawReset();

        // Three reset cycles, then SUB with memory always ready
        curOpc = OP_R;
        curF3  = 3'b000;
        curF7  = 1'b1;
        addReset(3);
        buildInstr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
        runTrace();

        // LW with two MEM_READ waits, SW with one MEM_WRITE wait
        buildInstr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 2);
        buildInstr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 1);
        runTrace();

        // Taken BEQ, untaken BNE, then LUI locks up until reset
        buildInstr(OP_B, 3'b000, 1'b0, 1'b1, 0, 0);
        buildInstr(OP_B, 3'b001, 1'b0, 1'b1, 0, 0);
        buildInstr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
        runTrace();

        // JAL, then an ADDI aborted by reset in its execute cycle
        buildInstr(OP_JAL, 3'b000, 1'b0, 1'b0, 1, 0);
        curOpc = OP_I;
        curF3  = 3'b000;
        curF7  = 1'b0;
        pushFetchDecode(0);
        c     = mux(blank(T_ABORT), 0, 2, 0, 2, 0, ADD);
        c.rst = 1'b1;
        trace.push_back(c);
        for (int i = 0; i < 2; i++) begin
            c          = mux(blank(T_FETCH), 0, 2, 0, 2, 0, ADD);
            c.memReady = 1'b0;
            trace.push_back(c);
        end
        runTrace();

        // Instruction-level table, each entry started from reset
        for (int i = 0; i < 19; i++) begin
            reset    = 1'b1;
            memReady = 1'b1;
            opcode   = vecs[i].opc;
            funct3   = vecs[i].f3;
            funct7b5 = vecs[i].f7;
            zero     = vecs[i].zero;
            @(posedge clock);
            #1;
            reset = 1'b0;
            cyc   = 0;
            pcW   = 0;
            regW  = 0;
            memW  = 0;
            ill   = 0;
            done  = 1'b0;
            for (int n = 1; n <= 12 && !done; n++) begin
                @(negedge clock);
                pcW  += int'(pcWrite);
                regW += int'(regWrite);
                memW += int'(memWrite);
                if (retire || illegal) begin
                    cyc  = n;
                    ill  = int'(illegal);
                    done = 1'b1;
                end else begin
                    @(posedge clock);
                    #1;
                end
            end
            vectors++;
            if (cyc != vecs[i].cycles || pcW != vecs[i].pcW || regW != vecs[i].regW ||
                memW != vecs[i].memW || ill != vecs[i].ill) begin
                miscompares++;
                $display("[TB] FAIL table[%0d] opc=%b f3=%b: got cycles=%0d pcW=%0d regW=%0d memW=%0d ill=%0d, want cycles=%0d pcW=%0d regW=%0d memW=%0d ill=%0d",
                         i, vecs[i].opc, vecs[i].f3, cyc, pcW, regW, memW, ill,
                         vecs[i].cycles, vecs[i].pcW, vecs[i].regW, vecs[i].memW, vecs[i].ill);
            end
            @(posedge clock);
            #1;
        end
        rawReset();

        // Random instruction stream with random memory wait states
        for (int k = 0; k < 200; k++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 7))
                0:       opc = OP_LW;
                1:       opc = OP_SW;
                2:       opc = OP_R;
                3:       opc = OP_I;
                4:       opc = OP_B;
                5:       opc = OP_JAL;
                6:       opc = OP_LUI;
                default: opc = 7'($urandom_range(0, 127));
            endcase
            buildInstr(opc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
            runTrace();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
